cw_key_shaper: RTL

//  Conditions the raw CW key input and generates the keying envelope for the sidetone path.

---
 rtl/cw_key_shaper.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cw_key_shaper.sv
// cw_key_shaper: debounces the CW key and shapes the sidetone keying envelope with PTT hang.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   cw_key_in    raw asynchronous key contact, active-high
//   cmd_addr     command slave address (6b)
//   cmd_data     command slave write data (32b)
//   cmd_rqst     command write strobe, one clk
//   cw_keydown   debounced key state
//   sidetone_sel sidetone enable to the audio stage
//   profile      envelope amplitude 0..127 to the audio stage
//   cw_ptt       transmit request including hang time
module cw_key_shaper #(
    parameter logic [16:0] CLK_FREQ_KHZ = 17'd76800,
    parameter logic [15:0] RAMP_DIV     = 16'd3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cw_key_in,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_rqst,
    output logic        cw_keydown,
    output logic        sidetone_sel,
    output logic [6:0]  profile,
    output logic        cw_ptt
);
    typedef enum logic [2:0] {IDLE, RISE, ON, FALL, HANG} state_t;
    state_t      state;
    logic        k1, k2, key_s, cw_en;
    logic [16:0] ms_cnt;
    logic        ms_tick, ramp_tick;
    logic [7:0]  deb_ms, deb_cnt;
    logic [9:0]  hang_ms, hang_cnt;
    logic [15:0] rp_cnt;
    logic        unused;
    always_comb begin
        key_s     = k2 & cw_en;
        ms_tick   = ms_cnt == CLK_FREQ_KHZ - 17'd1;
        ramp_tick = rp_cnt == RAMP_DIV - 16'd1;
        unused    = ^{cmd_data[31:25], cmd_data[23:18]};
    end
    // Synchronizer, ms timebase, config register and debouncer.
    // The debounce counter only advances while the synchronized key disagrees with
    // the accepted state, so any glitch shorter than deb_ms ms restarts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            k1         <= 1'b0;
            k2         <= 1'b0;
            ms_cnt     <= '0;
            deb_ms     <= 8'd5;
            hang_ms    <= '0;
            cw_en      <= 1'b1;
            deb_cnt    <= '0;
            cw_keydown <= 1'b0;
        end else begin
            k1     <= cw_key_in;
            k2     <= k1;
            ms_cnt <= ms_tick ? '0 : ms_cnt + 17'd1;
            if (cmd_rqst && cmd_addr == 6'h11) begin
                deb_ms  <= cmd_data[7:0];
                hang_ms <= cmd_data[17:8];
                cw_en   <= cmd_data[24];
            end
            if (key_s == cw_keydown)
                deb_cnt <= '0;
            else if (deb_cnt >= deb_ms) begin
                cw_keydown <= key_s;
                deb_cnt    <= '0;
            end else if (ms_tick && deb_cnt != 8'hFF)
                deb_cnt <= deb_cnt + 8'd1;
        end
    end
    // Envelope FSM. The ramp prescaler restarts on every state change so each new
    // ramp segment takes a full RAMP_DIV before its first step; a key change in
    // RISE/FALL takes priority over a coincident ramp step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            profile      <= '0;
            sidetone_sel <= 1'b0;
            cw_ptt       <= 1'b0;
            rp_cnt       <= '0;
            hang_cnt     <= '0;
        end else begin
            rp_cnt <= ramp_tick ? '0 : rp_cnt + 16'd1;
            case (state)
                IDLE: if (cw_keydown) begin
                    state        <= RISE;
                    sidetone_sel <= 1'b1;
                    cw_ptt       <= 1'b1;
                    rp_cnt       <= '0;
                end
                RISE: if (!cw_keydown) begin
                    state  <= FALL;
                    rp_cnt <= '0;
                end else if (ramp_tick) begin
                    if (profile >= 7'd126) begin
                        profile <= 7'd127;
                        state   <= ON;
                        rp_cnt  <= '0;
                    end else
                        profile <= profile + 7'd1;
                end
                ON: begin
                    profile <= 7'd127;
                    if (!cw_keydown) begin
                        state  <= FALL;
                        rp_cnt <= '0;
                    end
                end
                FALL: if (cw_keydown) begin
                    state  <= RISE;
                    rp_cnt <= '0;
                end else if (ramp_tick) begin
                    if (profile <= 7'd1) begin
                        profile      <= '0;
                        sidetone_sel <= 1'b0;
                        rp_cnt       <= '0;
                        if (hang_ms != '0) begin
                            state    <= HANG;
                            hang_cnt <= '0;
                        end else begin
                            state  <= IDLE;
                            cw_ptt <= 1'b0;
                        end
                    end else
                        profile <= profile - 7'd1;
                end
                HANG: if (cw_keydown) begin
                    state        <= RISE;
                    sidetone_sel <= 1'b1;
                    rp_cnt       <= '0;
                end else if (hang_cnt >= hang_ms) begin
                    state  <= IDLE;
                    cw_ptt <= 1'b0;
                    rp_cnt <= '0;
                end else if (ms_tick && hang_cnt != 10'h3FF)
                    hang_cnt <= hang_cnt + 10'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
